// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I-subset core, with a retired-instruction counter.
// Strobes are gated by the reset level so that no write is seen once reset asserts.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  output logic        pcWrite,
  output logic        adrSrc,
  output logic        irWrite,
  output logic        memWrite,
  output logic        regWrite,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluControl,
  output logic [2:0]  immSrc,
  output logic [1:0]  resultSrc,
  output logic        halted,
  output logic [31:0] instRetired
);

  localparam int unsigned CNT_W = 32;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALRPC   = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;
  localparam logic [3:0] S_HALT     = 4'd14;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  logic [3:0] state;
  logic [3:0] state_next;
  logic       pc_update;
  logic       branch;
  logic       taken;
  logic       ir_write;
  logic       mem_write;
  logic       reg_write;
  logic       retire;

  // funct3 -> ALU op shared by register and immediate arithmetic
  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_from_funct3 = sub ? ALU_SUB : ALU_ADD;
      3'b010:  alu_from_funct3 = ALU_SLT;
      3'b011:  alu_from_funct3 = ALU_SLTU;
      3'b100:  alu_from_funct3 = ALU_XOR;
      3'b110:  alu_from_funct3 = ALU_OR;
      3'b111:  alu_from_funct3 = ALU_AND;
      default: alu_from_funct3 = ALU_ADD;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // Next-state and Moore outputs
  always_comb begin
    state_next = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adrSrc     = 1'b0;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    aluControl = ALU_ADD;
    resultSrc  = 2'b00;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        aluSrcB    = 2'b10;
        resultSrc  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = (funct3 == 3'b010) ? S_MEMADR : S_HALT;
          OP_R:         state_next = (funct3[1:0] == 2'b01) ? S_HALT : S_EXECR;
          OP_I:         state_next = (funct3[1:0] == 2'b01) ? S_HALT : S_EXECI;
          OP_BR:        state_next = funct3[1] ? S_HALT : S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = S_JALR;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrSrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc  = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc     = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA    = 2'b10;
        aluControl = alu_from_funct3(funct3, funct7b5);
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        aluControl = alu_from_funct3(funct3, 1'b0);
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA    = 2'b10;
        branch     = 1'b1;
        aluControl = funct3[2] ? ALU_SLT : ALU_SUB;
        state_next = S_FETCH;
      end
      S_JAL: begin
        aluSrcA    = 2'b01;
        aluSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        state_next = S_JALRPC;
      end
      S_JALRPC: begin
        aluSrcA    = 2'b01;
        aluSrcB    = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        resultSrc  = 2'b11;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = S_HALT;
    endcase
  end

  // Branch condition: blt/bge read the slt result through the zero flag
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = !zero;
      3'b101:  taken = zero;
      default: taken = 1'b0;
    endcase
  end

  // Immediate format depends only on the opcode
  always_comb begin
    case (op)
      OP_SW:   immSrc = 3'b001;
      OP_BR:   immSrc = 3'b010;
      OP_JAL:  immSrc = 3'b011;
      OP_LUI:  immSrc = 3'b100;
      default: immSrc = 3'b000;
    endcase
  end

  assign pcWrite  = rst & (pc_update | (branch & taken));
  assign irWrite  = rst & ir_write;
  assign memWrite = rst & mem_write;
  assign regWrite = rst & reg_write;

  assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) || (state == S_ALUWB) ||
                  (state == S_BRANCH) || (state == S_LUI);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instRetired <= '0;
    else if (retire) instRetired <= instRetired + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: walks instructions state by state
// and compares strobes, selects and the retired counter against hand-derived values.
module tb_multicycle_controller;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        pcWrite;
  logic        adrSrc;
  logic        irWrite;
  logic        memWrite;
  logic        regWrite;
  logic [1:0]  aluSrcA;
  logic [1:0]  aluSrcB;
  logic [2:0]  aluControl;
  logic [2:0]  immSrc;
  logic [1:0]  resultSrc;
  logic        halted;
  logic [31:0] instRetired;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret = 32'd0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pcWrite(pcWrite), .adrSrc(adrSrc), .irWrite(irWrite), .memWrite(memWrite),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
    .immSrc(immSrc), .resultSrc(resultSrc), .halted(halted), .instRetired(instRetired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    exp_ret = 32'd0;
  endtask

  // Strobe vector is {pcWrite, irWrite, memWrite, regWrite}
  task automatic test_reset();
    rst = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({pcWrite, irWrite, memWrite, regWrite} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: got %b want 0000", {pcWrite, irWrite, memWrite, regWrite});
    end
    checks++;
    if (instRetired !== 32'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_halt: got cnt=%0d halted=%b want 0/0", instRetired, halted);
    end
    checks++;
    if ({adrSrc, aluSrcA, aluSrcB, resultSrc} !== 7'b0_00_10_10) begin
      errors++; $display("FAIL reset_fetch_sel: got %b want 0001010", {adrSrc, aluSrcA, aluSrcB, resultSrc});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pcWrite, irWrite} !== 2'b11) begin
      errors++; $display("FAIL release_fetch: got pc/ir=%b want 11", {pcWrite, irWrite});
    end
  endtask

  task automatic test_lw();
    op = 7'b0000011; funct3 = 3'b010;
    tick(); // DECODE
    checks++;
    if ({aluSrcA, aluSrcB, regWrite, irWrite} !== 6'b01_01_0_0) begin
      errors++; $display("FAIL lw_decode: got %b want 010100", {aluSrcA, aluSrcB, regWrite, irWrite});
    end
    tick(); // MEMADR
    checks++;
    if ({aluSrcA, aluSrcB, regWrite} !== 5'b10_01_0) begin
      errors++; $display("FAIL lw_memadr: got %b want 10010", {aluSrcA, aluSrcB, regWrite});
    end
    tick(); // MEMREAD
    checks++;
    if ({adrSrc, resultSrc, regWrite, memWrite} !== 5'b1_00_0_0) begin
      errors++; $display("FAIL lw_memread: got %b want 10000", {adrSrc, resultSrc, regWrite, memWrite});
    end
    tick(); // MEMWB
    checks++;
    if ({regWrite, resultSrc, instRetired} !== {1'b1, 2'b01, exp_ret}) begin
      errors++; $display("FAIL lw_memwb: got rw=%b rs=%b cnt=%0d want 1/01/%0d", regWrite, resultSrc, instRetired, exp_ret);
    end
    exp_ret++;
    tick(); // FETCH
    checks++;
    if ({irWrite, regWrite} !== 2'b10 || instRetired !== exp_ret) begin
      errors++; $display("FAIL lw_retire: got ir/rw=%b cnt=%0d want 10/%0d", {irWrite, regWrite}, instRetired, exp_ret);
    end
  endtask

  task automatic test_branch(input logic [2:0] f3, input logic z, input logic exp_pc, input logic [2:0] exp_alu);
    op = 7'b1100011; funct3 = f3;
    tick(); // DECODE
    checks++;
    if ({pcWrite, immSrc} !== 4'b0_010) begin
      errors++; $display("FAIL br_decode f3=%b: got pc=%b imm=%b want 0/010", f3, pcWrite, immSrc);
    end
    tick(); // BRANCH
    zero = z;
    #1;
    checks++;
    if ({pcWrite, aluControl, resultSrc, regWrite} !== {exp_pc, exp_alu, 2'b00, 1'b0}) begin
      errors++; $display("FAIL br_exec f3=%b z=%b: got pc=%b alu=%b want pc=%b alu=%b", f3, z, pcWrite, aluControl, exp_pc, exp_alu);
    end
    exp_ret++;
    tick(); // FETCH
    zero = 1'b0;
    checks++;
    if (irWrite !== 1'b1 || instRetired !== exp_ret) begin
      errors++; $display("FAIL br_retire f3=%b: got ir=%b cnt=%0d want 1/%0d", f3, irWrite, instRetired, exp_ret);
    end
  endtask

  task automatic test_jalr();
    op = 7'b1100111; funct3 = 3'b000;
    tick(); // DECODE
    tick(); // JALR
    checks++;
    if ({pcWrite, aluSrcA, aluSrcB} !== 5'b0_10_01) begin
      errors++; $display("FAIL jalr_calc: got %b want 01001", {pcWrite, aluSrcA, aluSrcB});
    end
    tick(); // JALRPC
    checks++;
    if ({pcWrite, aluSrcA, aluSrcB, resultSrc, regWrite} !== 8'b1_01_10_00_0) begin
      errors++; $display("FAIL jalr_pc: got %b want 10110000", {pcWrite, aluSrcA, aluSrcB, resultSrc, regWrite});
    end
    tick(); // ALUWB
    checks++;
    if ({pcWrite, regWrite, irWrite} !== 3'b010) begin
      errors++; $display("FAIL jalr_wb: got %b want 010", {pcWrite, regWrite, irWrite});
    end
    exp_ret++;
    tick(); // FETCH after 5 cycles
    checks++;
    if (irWrite !== 1'b1 || instRetired !== exp_ret) begin
      errors++; $display("FAIL jalr_len: got ir=%b cnt=%0d want 1/%0d", irWrite, instRetired, exp_ret);
    end
  endtask

  task automatic test_jal();
    op = 7'b1101111; funct3 = 3'b000;
    tick(); // DECODE
    checks++;
    if (immSrc !== 3'b011) begin
      errors++; $display("FAIL jal_imm: got %b want 011", immSrc);
    end
    tick(); // JAL
    checks++;
    if ({pcWrite, regWrite, aluSrcA, aluSrcB} !== 6'b1_0_01_10) begin
      errors++; $display("FAIL jal_exec: got %b want 100110", {pcWrite, regWrite, aluSrcA, aluSrcB});
    end
    tick(); // ALUWB
    checks++;
    if ({regWrite, resultSrc} !== 3'b1_00) begin
      errors++; $display("FAIL jal_wb: got %b want 100", {regWrite, resultSrc});
    end
    exp_ret++;
    tick();
  endtask

  task automatic test_r_then_halt();
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); // DECODE
    tick(); // EXECR
    checks++;
    if ({aluControl, aluSrcA, aluSrcB} !== 7'b001_10_00) begin
      errors++; $display("FAIL r_sub: got %b want 0011000", {aluControl, aluSrcA, aluSrcB});
    end
    tick(); // ALUWB
    exp_ret++;
    tick(); // FETCH
    funct7b5 = 1'b0;
    checks++;
    if (instRetired !== exp_ret) begin
      errors++; $display("FAIL r_retire: got %0d want %0d", instRetired, exp_ret);
    end
    op = 7'b1111111;
    tick(); // DECODE
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_early: got %b want 0", halted);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({halted, pcWrite, irWrite, memWrite, regWrite} !== 5'b10000 || instRetired !== exp_ret) begin
        errors++; $display("FAIL halt_hold cyc=%0d: got %b cnt=%0d want 10000/%0d", i, {halted, pcWrite, irWrite, memWrite, regWrite}, instRetired, exp_ret);
      end
    end
  endtask

  task automatic test_bad_funct3();
    do_reset();
    op = 7'b0000011; funct3 = 3'b000;
    tick(); // DECODE
    tick();
    checks++;
    if ({halted, regWrite, pcWrite} !== 3'b100) begin
      errors++; $display("FAIL lw_bad_f3: got %b want 100", {halted, regWrite, pcWrite});
    end
    do_reset();
    op = 7'b1100011; funct3 = 3'b110;
    tick();
    tick();
    checks++;
    if ({halted, pcWrite} !== 2'b10) begin
      errors++; $display("FAIL br_bad_f3: got %b want 10", {halted, pcWrite});
    end
  endtask

  task automatic test_lui_sw_abort();
    do_reset();
    op = 7'b0110111; funct3 = 3'b000;
    tick(); // DECODE
    checks++;
    if (immSrc !== 3'b100) begin
      errors++; $display("FAIL lui_imm: got %b want 100", immSrc);
    end
    tick(); // LUI
    checks++;
    if ({regWrite, resultSrc} !== 3'b1_11) begin
      errors++; $display("FAIL lui_wb: got %b want 111", {regWrite, resultSrc});
    end
    exp_ret++;
    tick(); // FETCH
    op = 7'b0100011; funct3 = 3'b010;
    tick(); // DECODE
    tick(); // MEMADR
    tick(); // MEMWRITE
    checks++;
    if ({memWrite, adrSrc, instRetired} !== {2'b11, exp_ret}) begin
      errors++; $display("FAIL sw_memwrite: got mw=%b adr=%b cnt=%0d want 1/1/%0d", memWrite, adrSrc, instRetired, exp_ret);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({memWrite, pcWrite, irWrite, regWrite} !== 4'b0000) begin
      errors++; $display("FAIL sw_abort: got %b want 0000", {memWrite, pcWrite, irWrite, regWrite});
    end
    tick();
    rst = 1'b1;
    #1;
    exp_ret = 32'd0;
    checks++;
    if ({irWrite, pcWrite} !== 2'b11 || instRetired !== exp_ret) begin
      errors++; $display("FAIL sw_recover: got ir/pc=%b cnt=%0d want 11/0", {irWrite, pcWrite}, instRetired);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_branch(3'b000, 1'b1, 1'b1, 3'b001);
    test_branch(3'b001, 1'b1, 1'b0, 3'b001);
    test_branch(3'b100, 1'b0, 1'b1, 3'b101);
    test_jalr();
    test_jal();
    test_r_then_halt();
    test_bad_funct3();
    test_lui_sw_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
